// File: rtl/ysyx_23060303_regfile_sb_pkg.sv
// Shared types and constants for the scoreboarded register file.
package ysyx_23060303_rf_pkg;

  typedef enum logic [0:0] {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_e;

  localparam int RF_ADDR_WIDTH = 5;
  localparam int RF_DATA_WIDTH = 32;
  localparam int RF_NREAD      = 2;

  // Low bit of a port's field inside a packed multi-port bus.
  function automatic int port_lsb(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/ysyx_23060303_regfile_sb_if.sv
// Decode/issue and writeback bus of the register file.
interface ysyx_23060303_regfile_sb_if
  import ysyx_23060303_rf_pkg::*;
#(
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int NREAD      = RF_NREAD
);

  logic [NREAD*ADDR_WIDTH-1:0] raddr;
  logic [NREAD*DATA_WIDTH-1:0] rdata;
  logic [NREAD-1:0]            rs_busy;
  logic                        wen;
  logic [ADDR_WIDTH-1:0]       waddr;
  logic [DATA_WIDTH-1:0]       wdata;
  logic                        issue_en;
  logic [ADDR_WIDTH-1:0]       issue_rd;

  // Core side: drives addresses, writeback and issue; consumes operands.
  modport master (
    output raddr, wen, waddr, wdata, issue_en, issue_rd,
    input  rdata, rs_busy
  );

  // Register file side.
  modport slave (
    input  raddr, wen, waddr, wdata, issue_en, issue_rd,
    output rdata, rs_busy
  );

endinterface

// File: rtl/ysyx_23060303_rf_read_port.sv
// One read port: writeback bypass, register-0 masking and INIT masking.
module ysyx_23060303_rf_read_port
  import ysyx_23060303_rf_pkg::*;
#(
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int ZERO_REG   = 1
) (
  input  logic [ADDR_WIDTH-1:0] raddr,
  input  logic [DATA_WIDTH-1:0] rf_word,
  input  logic                  busy_bit,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  run,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rs_busy
);

  logic zero_hit;
  assign zero_hit = (ZERO_REG != 0) && (raddr == '0);

  // Same-cycle writeback wins over storage; the write also retires the producer.
  always_comb begin
    rdata   = '0;
    rs_busy = 1'b0;
    if (run && !zero_hit) begin
      if (wen && (waddr == raddr)) begin
        rdata   = wdata;
        rs_busy = 1'b0;
      end else begin
        rdata   = rf_word;
        rs_busy = busy_bit;
      end
    end
  end

endmodule

// File: rtl/ysyx_23060303_regfile_sb.sv
// Register file with N read ports, bypass, busy scoreboard and zeroing sweep.
module ysyx_23060303_regfile_sb
  import ysyx_23060303_rf_pkg::*;
#(
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int NREAD      = RF_NREAD,
  parameter int ZERO_REG   = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        init_done,
  ysyx_23060303_regfile_sb_if.slave   bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] rf [DEPTH];
  logic [DEPTH-1:0]      busy_reg;
  logic [DEPTH-1:0]      busy_next;
  logic [ADDR_WIDTH-1:0] cnt_reg;
  rf_state_e             state_reg;
  logic                  init_done_reg;
  logic                  run;
  logic                  zero_w;
  logic                  zero_issue;

  assign run        = (state_reg == RF_RUN);
  assign init_done  = init_done_reg;
  assign zero_w     = (ZERO_REG != 0) && (bus.waddr == '0);
  assign zero_issue = (ZERO_REG != 0) && (bus.issue_rd == '0);

  // Scoreboard: writeback clears first, issue sets after so a new producer wins.
  always_comb begin
    busy_next = busy_reg;
    if (run) begin
      if (bus.wen) begin
        busy_next[bus.waddr] = 1'b0;
      end
      if (bus.issue_en && !zero_issue) begin
        busy_next[bus.issue_rd] = 1'b1;
      end
    end
  end

  // Control FSM: sweep every register once after reset, then run.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= RF_INIT;
      cnt_reg       <= '0;
      busy_reg      <= '0;
      init_done_reg <= 1'b0;
    end else begin
      busy_reg <= busy_next;
      case (state_reg)
        RF_INIT: begin
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == '1) begin
            state_reg     <= RF_RUN;
            init_done_reg <= 1'b1;
          end
        end
        RF_RUN: begin
          state_reg <= RF_RUN;
        end
        default: begin
          state_reg <= RF_INIT;
        end
      endcase
    end
  end

  // Storage write port shared by the zeroing sweep and writeback.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_reg == RF_INIT) begin
        rf[cnt_reg] <= '0;
      end else if (bus.wen && !zero_w) begin
        rf[bus.waddr] <= bus.wdata;
      end
    end
  end

  for (genvar gi = 0; gi < NREAD; gi++) begin : g_rd
    localparam int AL = port_lsb(gi, ADDR_WIDTH);
    localparam int DL = port_lsb(gi, DATA_WIDTH);

    logic [ADDR_WIDTH-1:0] addr;
    assign addr = bus.raddr[AL +: ADDR_WIDTH];

    ysyx_23060303_rf_read_port #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .ZERO_REG   (ZERO_REG)
    ) u_port (
      .raddr    (addr),
      .rf_word  (rf[addr]),
      .busy_bit (busy_reg[addr]),
      .wen      (bus.wen),
      .waddr    (bus.waddr),
      .wdata    (bus.wdata),
      .run      (run),
      .rdata    (bus.rdata[DL +: DATA_WIDTH]),
      .rs_busy  (bus.rs_busy[gi])
    );
  end

endmodule

// File: tb/tb_ysyx_23060303_regfile_sb.sv
// Bench for the scoreboarded register file: directed scenarios plus random traffic.
module tb_ysyx_23060303_regfile_sb;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int NR    = 2;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic rst;
  logic init_done;

  always #5 clk = ~clk;

  ysyx_23060303_regfile_sb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NREAD(NR)) bus ();

  ysyx_23060303_regfile_sb #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NREAD      (NR),
    .ZERO_REG   (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .init_done (init_done),
    .bus       (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_txn    = 0;

  // Reference model: architectural contents, busy set, sweep progress.
  logic [DW-1:0] m_rf [DEPTH];
  bit            m_busy [DEPTH];
  bit            m_run   = 1'b0;
  int            m_sweep = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Apply the architectural effect of one rising edge to the model.
  task automatic model_edge();
    if (rst) begin
      m_run   = 1'b0;
      m_sweep = 0;
      for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
    end else if (!m_run) begin
      m_rf[m_sweep] = '0;
      m_sweep++;
      if (m_sweep == DEPTH) m_run = 1'b1;
    end else begin
      if (bus.wen && bus.waddr != 0) m_rf[bus.waddr] = bus.wdata;
      if (bus.wen) m_busy[bus.waddr] = 1'b0;
      if (bus.issue_en && bus.issue_rd != 0) m_busy[bus.issue_rd] = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic drive(input bit wen, input int wa, input logic [31:0] wd,
                       input bit iss, input int ird, input int ra0, input int ra1);
    bus.wen      = wen;
    bus.waddr    = AW'(wa);
    bus.wdata    = wd;
    bus.issue_en = iss;
    bus.issue_rd = AW'(ird);
    bus.raddr    = {AW'(ra1), AW'(ra0)};
  endtask

  // Compare every read port and init_done with the model, one line per transaction.
  task automatic check_ports(input string tag);
    logic [AW-1:0] a;
    logic [DW-1:0] ed;
    bit            eb;
    #1;
    n_txn++;
    $display("txn %0d %s: ra0=%0d ra1=%0d wen=%0b wa=%0d wd=%08h iss=%0b ird=%0d -> rd0=%08h rd1=%08h busy=%b done=%0b",
             n_txn, tag, bus.raddr[AW-1:0], bus.raddr[2*AW-1:AW], bus.wen, bus.waddr, bus.wdata,
             bus.issue_en, bus.issue_rd, bus.rdata[DW-1:0], bus.rdata[2*DW-1:DW], bus.rs_busy, init_done);
    for (int i = 0; i < NR; i++) begin
      a  = bus.raddr[i*AW +: AW];
      ed = '0;
      eb = 1'b0;
      if (m_run && a != 0) begin
        if (bus.wen && bus.waddr == a) begin
          ed = bus.wdata;
        end else begin
          ed = m_rf[a];
          eb = m_busy[a];
        end
      end
      check($sformatf("%s_rdata%0d", tag, i), bus.rdata[i*DW +: DW], ed);
      check($sformatf("%s_busy%0d", tag, i), 32'(bus.rs_busy[i]), 32'(eb));
    end
    check($sformatf("%s_init_done", tag), 32'(init_done), 32'(m_run));
  endtask

  // Release reset and count edges until init_done is seen, bounded.
  task automatic run_sweep(input string tag, input bit poke_r5);
    int cycles;
    cycles = 0;
    rst = 1'b0;
    if (poke_r5) drive(1, 5, 32'hDEAD, 1, 6, 5, 6);
    else         drive(0, 0, 0, 0, 0, 0, 0);
    while (!init_done && cycles < 100) begin
      tick();
      cycles++;
      if (cycles == 20) drive(0, 0, 0, 0, 0, 5, 6);
      check_ports(tag);
    end
    check({tag, "_latency"}, 32'(cycles), 32'd32);
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    check_ports("reset");
    check("reset_rdata0", bus.rdata[DW-1:0], 32'h0);
    check("reset_done", 32'(init_done), 32'h0);

    // Writeback during the sweep must be lost.
    run_sweep("sweep", 1'b1);
    drive(0, 0, 0, 0, 0, 5, 6);
    check_ports("post_init");
    check("r5_after_init", bus.rdata[DW-1:0], 32'h0);
    check("r6_not_busy", 32'(bus.rs_busy[1]), 32'h0);

    // Write with same-cycle read through the bypass.
    drive(1, 3, 32'h12345678, 0, 0, 3, 3);
    check_ports("bypass_w3");
    check("r3_bypass", bus.rdata[DW-1:0], 32'h12345678);
    tick();
    drive(0, 0, 0, 0, 0, 3, 0);
    check_ports("r3_stored");
    check("r3_stored", bus.rdata[DW-1:0], 32'h12345678);

    // Register 0 ignores writes and issue.
    drive(1, 0, 32'hFFFFFFFF, 1, 0, 0, 0);
    check_ports("r0_wr");
    check("r0_bypass_blocked", bus.rdata[DW-1:0], 32'h0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    check_ports("r0_rd");
    check("r0_data", bus.rdata[DW-1:0], 32'h0);
    check("r0_busy", 32'(bus.rs_busy[0]), 32'h0);

    // Busy set latency and clear via bypass.
    drive(0, 0, 0, 1, 7, 7, 7);
    check_ports("r7_issue");
    check("r7_busy_N", 32'(bus.rs_busy[0]), 32'h0);
    tick();
    drive(0, 0, 0, 0, 0, 7, 7);
    check_ports("r7_N1");
    check("r7_busy_N1", 32'(bus.rs_busy[0]), 32'h1);
    tick();
    check_ports("r7_N2");
    tick();
    drive(1, 7, 32'hA5, 0, 0, 7, 7);
    check_ports("r7_wb");
    check("r7_busy_N3", 32'(bus.rs_busy[1]), 32'h0);
    check("r7_data_N3", bus.rdata[2*DW-1:DW], 32'hA5);
    tick();

    // Same-cycle issue and writeback: data lands, busy stays set.
    drive(1, 9, 32'h55, 1, 9, 9, 9);
    check_ports("r9_both");
    tick();
    drive(0, 0, 0, 0, 0, 9, 9);
    check_ports("r9_next");
    check("r9_data", bus.rdata[DW-1:0], 32'h55);
    check("r9_busy", 32'(bus.rs_busy[0]), 32'h1);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      tick();
      drive($urandom_range(1, 0) == 1, $urandom_range(DEPTH-1, 0), $urandom,
            $urandom_range(2, 0) == 0, $urandom_range(DEPTH-1, 0),
            $urandom_range(DEPTH-1, 0), (n % 4 == 0) ? int'(bus.waddr) : $urandom_range(DEPTH-1, 0));
      check_ports("rand");
    end
    tick();

    // Reset in the middle of the sweep with a busy register outstanding.
    drive(0, 0, 0, 1, 4, 4, 0);
    tick();
    drive(0, 0, 0, 0, 0, 4, 0);
    check_ports("r4_busy");
    check("r4_busy_set", 32'(bus.rs_busy[0]), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (10) tick();
    check_ports("mid_sweep");
    rst = 1'b1;
    tick();
    check_ports("re_reset");
    run_sweep("resweep", 1'b0);
    drive(0, 0, 0, 0, 0, 4, 3);
    check_ports("r4_after");
    check("r4_cleared", 32'(bus.rs_busy[0]), 32'h0);
    check("r3_zeroed", bus.rdata[2*DW-1:DW], 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
